// File: rtl/spi_slave_regbank_pkg.sv
// ---------------------------------------------------------------------------
// spi_regbank_pkg
// Shared constants and types for the SPI slave register bank.
//   FRAME_W / ADDR_W / DATA_W : frame geometry {rw, addr[6:0], data[7:0]}
//   CNT_W                     : width of the SCLK rise counter (0..16)
//   RW_BIT .. DATA_LSB        : bit positions of the fields inside a frame
//   spi_state_e               : frame-decoder FSM states
// ---------------------------------------------------------------------------
package spi_regbank_pkg;

    localparam int FRAME_W  = 16;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 5;

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_slave_regbank_if.sv
// ---------------------------------------------------------------------------
// spi_slave_regbank_if
// SPI pin bundle between an SPI master and the register bank.
//   spi_csn_i  : chip select, active low
//   spi_sclk_i : SPI clock, mode 0
//   spi_mosi_i : master-out data, MSB first
//   spi_miso_o : slave-out data, MSB first
// Modports: slave (register bank side), master (stimulus side).
// ---------------------------------------------------------------------------
interface spi_slave_regbank_if;

    logic spi_csn_i;
    logic spi_sclk_i;
    logic spi_mosi_i;
    logic spi_miso_o;

    modport slave (
        input  spi_csn_i,
        input  spi_sclk_i,
        input  spi_mosi_i,
        output spi_miso_o
    );

    modport master (
        output spi_csn_i,
        output spi_sclk_i,
        output spi_mosi_i,
        input  spi_miso_o
    );

endinterface

// File: rtl/spi_slave_regbank_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Multi-stage synchronizer for an asynchronous pin plus registered rise/fall
// pulse detection. A pin edge shows up as a one-cycle pulse STAGES+1 cycles
// later.
//   sys_clk_i  : sampling clock
//   sys_rstn_i : asynchronous active-low reset
//   async_i    : raw pin
//   sync_o     : synchronized level
//   rise_o     : one-cycle pulse on a synchronized 0->1 transition
//   fall_o     : one-cycle pulse on a synchronized 1->0 transition
// RST_VAL is the level the chain assumes out of reset.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk_i,
    input  logic sys_rstn_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES:0]   chain_s;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    assign chain_s = {sync_q, async_i};
    assign sync_o  = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

    // Synchronizer chain and edge pulse registers.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= chain_s[STAGES-1:0];
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/spi_slave_regbank.sv
// ---------------------------------------------------------------------------
// spi_slave_regbank
// SPI mode-0 slave decoding 16-bit frames {rw, addr[6:0], data[7:0]} into a
// bank of NUM_REGS 8-bit configuration registers. All pins are oversampled
// in sys_clk_i. Read data is returned on MISO within the same frame.
//   sys_clk_i   : system clock (only clock)
//   sys_rstn_i  : asynchronous active-low reset
//   spi         : SPI pins (slave modport of spi_slave_regbank_if)
//   regs_o      : register contents, reg k at [8k+7:8k]
//   wr_stb_o    : one-cycle pulse per committed write
//   wr_addr_o   : address of the last committed write
//   frame_err_o : one-cycle pulse per aborted frame
// Build option: SPI_REGBANK_FRAME_ERR_EN enables frame_err_o; without it the
// output is tied low (aborts are still handled).
// ---------------------------------------------------------------------------
module spi_slave_regbank
    import spi_regbank_pkg::*;
#(
    parameter int NUM_REGS    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    spi_slave_regbank_if.slave    spi,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_stb_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic                  frame_err_o
);

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS));
    endfunction

    logic sclk_rise_s;
    logic sclk_fall_s;
    logic csn_rise_s;
    logic csn_fall_s;
    logic mosi_s;
    logic sclk_sync_unused_s;
    logic csn_sync_unused_s;
    logic mosi_rise_unused_s;
    logic mosi_fall_unused_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .async_i    (spi.spi_sclk_i),
        .sync_o     (sclk_sync_unused_s),
        .rise_o     (sclk_rise_s),
        .fall_o     (sclk_fall_s)
    );

    // CSn assumes "low" out of reset so that a reset taken mid-frame cannot
    // fabricate a falling edge; a new frame needs a real high-then-low.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csn_sync (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .async_i    (spi.spi_csn_i),
        .sync_o     (csn_sync_unused_s),
        .rise_o     (csn_rise_s),
        .fall_o     (csn_fall_s)
    );

    // MOSI is stable around SCLK rise, so its level lines up with the
    // (one cycle later) registered rise pulse.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .async_i    (spi.spi_mosi_i),
        .sync_o     (mosi_s),
        .rise_o     (mosi_rise_unused_s),
        .fall_o     (mosi_fall_unused_s)
    );

    spi_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-2:0]       shift_q, shift_d;
    logic                    rw_q, rw_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       rd_q, rd_d;
    logic                    miso_q, miso_d;
    logic                    wr_stb_q;
    logic [ADDR_W-1:0]       wr_addr_q;
    logic [DATA_W-1:0]       regs_q [NUM_REGS];

    logic [DATA_W-1:0]       byte_s;
    logic                    hdr_rw_s;
    logic [ADDR_W-1:0]       hdr_addr_s;
    logic [DATA_W-1:0]       rd_byte_s;
    logic                    commit_s;
    logic                    abort_s;

    // Byte completed by the current rise: seven shifted bits plus live MOSI.
    assign byte_s     = {shift_q, mosi_s};
    assign hdr_rw_s   = byte_s[RW_BIT - DATA_W];
    assign hdr_addr_s = byte_s[ADDR_MSB - DATA_W : ADDR_LSB - DATA_W];

    // Read snapshot of the addressed register; unimplemented addresses read 0.
    always_comb begin
        rd_byte_s = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            if (hdr_addr_s == ADDR_W'(k)) begin
                rd_byte_s = regs_q[k];
            end else begin
                rd_byte_s = rd_byte_s;
            end
        end
    end

    // Frame decoder next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        miso_d   = miso_q;
        commit_s = 1'b0;
        abort_s  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = {CNT_W{1'b0}};
                miso_d = 1'b0;
                if (csn_fall_s) begin
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (csn_rise_s) begin
                    abort_s = 1'b1;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_rise_s) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = byte_s[DATA_W-2:0];
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        rw_d    = hdr_rw_s;
                        addr_d  = hdr_addr_s;
                        state_d = DATA;
                        if (hdr_rw_s) begin
                            miso_d = rd_byte_s[DATA_W-1];
                            rd_d   = {rd_byte_s[DATA_W-2:0], 1'b0};
                        end else begin
                            miso_d = 1'b0;
                            rd_d   = {DATA_W{1'b0}};
                        end
                    end else begin
                        state_d = ADDR;
                    end
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                // The final rise wins over a simultaneous CSn rise.
                if (sclk_rise_s && (cnt_q == CNT_W'(FRAME_W - 1))) begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = HOLD;
                    commit_s = ~rw_q & addr_in_range(addr_q);
                end else if (csn_rise_s) begin
                    abort_s = 1'b1;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_rise_s) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = byte_s[DATA_W-2:0];
                end else if (sclk_fall_s) begin
                    miso_d = rd_q[DATA_W-1];
                    rd_d   = {rd_q[DATA_W-2:0], 1'b0};
                end else begin
                    state_d = DATA;
                end
            end
            HOLD: begin
                if (csn_rise_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame decoder state registers and write strobe/address outputs.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            shift_q   <= {(DATA_W-1){1'b0}};
            rw_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            rd_q      <= {DATA_W{1'b0}};
            miso_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            miso_q    <= miso_d;
            wr_stb_q  <= commit_s;
            wr_addr_q <= commit_s ? addr_q : wr_addr_q;
        end
    end

    // Register bank storage; byte_s holds the data field on the commit cycle.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit_s && (addr_q == ADDR_W'(k))) begin
                    regs_q[k] <= byte_s[DATA_MSB:DATA_LSB];
                end else begin
                    regs_q[k] <= regs_q[k];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[g*8 +: 8] = regs_q[g];
    end

`ifdef SPI_REGBANK_FRAME_ERR_EN
    logic err_q;

    // One-cycle abort pulse.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort_s;
        end
    end

    assign frame_err_o = err_q;
`else
    // Abort still drives the FSM; only the report is compiled out.
    logic abort_unused_s;
    assign abort_unused_s = abort_s;
    assign frame_err_o    = 1'b0;
`endif

    assign spi.spi_miso_o = miso_q;
    assign wr_stb_o       = wr_stb_q;
    assign wr_addr_o      = wr_addr_q;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_regbank
// Directed plus randomized SPI frames against a register-array reference
// model of the bank; checks registers, read data, strobes and abort pulses.
// ---------------------------------------------------------------------------
module tb_spi_slave_regbank;

    localparam int NUM_REGS = 6;
    localparam int SYNC     = 2;
    localparam int HALF     = 8;
`ifdef SPI_REGBANK_FRAME_ERR_EN
    localparam int ERR_EN   = 1;
`else
    localparam int ERR_EN   = 0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spi_slave_regbank_if spi_if ();

    logic [NUM_REGS*8-1:0] regs;
    logic                  wr_stb;
    logic [6:0]            wr_addr;
    logic                  frame_err;

    spi_slave_regbank #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC)) dut (
        .sys_clk_i   (clk),
        .sys_rstn_i  (rstn),
        .spi         (spi_if),
        .regs_o      (regs),
        .wr_stb_o    (wr_stb),
        .wr_addr_o   (wr_addr),
        .frame_err_o (frame_err)
    );

    int errors = 0;
    int checks = 0;
    int stb_cnt = 0;
    int err_cnt = 0;

    always @(posedge clk) begin
        if (wr_stb === 1'b1) stb_cnt <= stb_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    logic [7:0]            mdl [0:127];
    logic [6:0]            exp_waddr = 7'd0;
    logic                  miso_s [1:32];
    int                    rise_n;
    logic [NUM_REGS*8-1:0] regs4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS*8-1:0] model_regs();
        logic [NUM_REGS*8-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[k*8 +: 8] = mdl[k];
        return v;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        spi_if.spi_csn_i = 1'b0;
        rise_n = 0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        spi_if.spi_csn_i = 1'b1;
        wait_clk(HALF);
    endtask

    // One SCLK period: MOSI set in the low phase, MISO sampled at the end of
    // the high phase, registers snapshotted 4 cycles after the rise.
    task automatic sclk_bit(input logic b);
        spi_if.spi_mosi_i = b;
        wait_clk(HALF);
        spi_if.spi_sclk_i = 1'b1;
        rise_n++;
        wait_clk(4);
        regs4 = regs;
        wait_clk(HALF - 5);
        miso_s[rise_n] = spi_if.spi_miso_o;
        wait_clk(1);
        spi_if.spi_sclk_i = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f, input int n);
        cs_low();
        for (int i = 0; i < n; i++) begin
            if (i < 16) sclk_bit(f[15-i]);
            else        sclk_bit(1'($urandom_range(0, 1)));
        end
        cs_high();
    endtask

    task automatic run_frame(input logic [15:0] f, input int n, input string tag);
        int         a;
        int         stb0;
        int         err0;
        int         exp_stb;
        int         exp_err;
        logic [7:0] exp_rd;
        logic [7:0] rd;
        logic [6:0] head;
        a      = int'(f[14:8]);
        exp_rd = (a < NUM_REGS) ? mdl[a] : 8'h00;
        stb0   = stb_cnt;
        err0   = err_cnt;
        send_frame(f, n);
        exp_stb = 0;
        exp_err = 0;
        if (n >= 16) begin
            if (!f[15] && a < NUM_REGS) begin
                mdl[a]    = f[7:0];
                exp_stb   = 1;
                exp_waddr = 7'(a);
            end
        end else begin
            exp_err = ERR_EN;
        end
        check({tag, "_regs"}, 64'(regs), 64'(model_regs()));
        check({tag, "_stb"}, 64'(stb_cnt - stb0), 64'(exp_stb));
        check({tag, "_err"}, 64'(err_cnt - err0), 64'(exp_err));
        check({tag, "_waddr"}, 64'(wr_addr), 64'(exp_waddr));
        if (n >= 16) begin
            for (int r = 1; r <= 7; r++) head[7-r] = miso_s[r];
            for (int r = 8; r <= 15; r++) rd[15-r] = miso_s[r];
            check({tag, "_miso_head"}, 64'(head), 64'd0);
            check({tag, "_rdata"}, 64'(rd), f[15] ? 64'(exp_rd) : 64'd0);
        end
    endtask

    initial begin
        int stb0;
        int err0;
        logic [15:0] f;
        int n;
        for (int k = 0; k < 128; k++) mdl[k] = 8'h00;
        spi_if.spi_csn_i  = 1'b1;
        spi_if.spi_sclk_i = 1'b0;
        spi_if.spi_mosi_i = 1'b0;
        wait_clk(5);
        check("rst_regs", 64'(regs), 64'd0);
        check("rst_miso", 64'(spi_if.spi_miso_o), 64'd0);
        check("rst_stb", 64'(wr_stb), 64'd0);
        check("rst_waddr", 64'(wr_addr), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        rstn = 1'b1;
        wait_clk(5);

        run_frame(16'h035A, 16, "wr3");
        check("wr3_lat4", 64'(regs4[31:24]), 64'h5A);
        run_frame(16'h00C3, 16, "wr0");
        run_frame(16'h80FF, 16, "rd0");
        run_frame(16'h0677, 16, "wr6");
        run_frame(16'h8600, 16, "rd6");
        run_frame(16'h0211, 10, "abort2");
        run_frame(16'h01AB, 20, "over1");
        run_frame(16'h8300, 16, "rd3");

        // Final rise and CSn rise land together: commit, no error.
        stb0 = stb_cnt;
        err0 = err_cnt;
        f = 16'h05E7;
        cs_low();
        for (int i = 0; i < 15; i++) sclk_bit(f[15-i]);
        spi_if.spi_mosi_i = f[0];
        wait_clk(HALF);
        spi_if.spi_sclk_i = 1'b1;
        spi_if.spi_csn_i  = 1'b1;
        wait_clk(HALF);
        spi_if.spi_sclk_i = 1'b0;
        wait_clk(HALF);
        mdl[5] = 8'hE7;
        exp_waddr = 7'd5;
        check("simul_regs", 64'(regs), 64'(model_regs()));
        check("simul_stb", 64'(stb_cnt - stb0), 64'd1);
        check("simul_err", 64'(err_cnt - err0), 64'd0);

        // Reset in the middle of a write frame.
        stb0 = stb_cnt;
        err0 = err_cnt;
        f = 16'h0299;
        cs_low();
        for (int i = 0; i < 12; i++) sclk_bit(f[15-i]);
        rstn = 1'b0;
        wait_clk(2);
        check("mrst_regs", 64'(regs), 64'd0);
        check("mrst_miso", 64'(spi_if.spi_miso_o), 64'd0);
        check("mrst_stb", 64'(wr_stb), 64'd0);
        check("mrst_waddr", 64'(wr_addr), 64'd0);
        check("mrst_err", 64'(frame_err), 64'd0);
        for (int k = 0; k < 128; k++) mdl[k] = 8'h00;
        exp_waddr = 7'd0;
        rstn = 1'b1;
        wait_clk(2);
        for (int i = 12; i < 16; i++) sclk_bit(f[15-i]);
        cs_high();
        check("post_rst_regs", 64'(regs), 64'd0);
        check("post_rst_stb", 64'(stb_cnt - stb0), 64'd0);
        check("post_rst_err", 64'(err_cnt - err0), 64'd0);
        run_frame(16'h0433, 16, "wr4");

        // Randomized frames, including truncated and over-long ones.
        for (int t = 0; t < 14; t++) begin
            f[15]   = 1'($urandom_range(0, 1));
            f[14:8] = 7'($urandom_range(0, 7));
            f[7:0]  = 8'($urandom);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 20);
            run_frame(f, n, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
